// File: rtl/encdec_pkg.sv
// Shared constants, width helper and default-width types for the one-hot encoder/decoder.
package encdec_pkg;

  localparam int DEFAULT_N = 4;

  // Ceiling log2, usable in constant expressions (parameter and port widths).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < value) begin
        result = b + 1;
      end
    end
    return result;
  endfunction

  localparam int DEFAULT_W = clog2(DEFAULT_N);

  typedef logic [DEFAULT_W-1:0] code_t;
  typedef logic [DEFAULT_N-1:0] onehot_t;

endpackage

// File: rtl/onehot_enc_stage.sv
// Registered one-hot to binary encoder with an illegal-input flag aligned to the code.
// Define ENCDEC_PRIORITY_EN to encode multi-hot inputs by their highest set bit instead of flagging them.
module onehot_enc_stage
  import encdec_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] i,
  output logic [W-1:0] y,
  output logic         y_valid,
  output logic         err
);

  logic [W-1:0] y_q, y_d;
  logic         y_valid_q, y_valid_d;
  logic         err_q, err_d;
  logic [W-1:0] highIdx;
  logic         isZero;
  logic         legal;

  // Highest set bit doubles as the index of a true one-hot input.
  always_comb begin
    highIdx = '0;
    for (int k = 0; k < N; k++) begin
      if (i[k]) begin
        highIdx = W'(k);
      end
    end
  end

  assign isZero = (i == '0);

`ifdef ENCDEC_PRIORITY_EN
  assign legal = !isZero;
`else
  logic isOneHot;
  assign isOneHot = ($countones(i) == 1);
  assign legal    = isOneHot;
`endif

  always_comb begin
    y_d       = y_q;
    y_valid_d = 1'b0;
    err_d     = 1'b0;
    if (in_valid) begin
      if (legal) begin
        y_d       = highIdx;
        y_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      err_q     <= err_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign err     = err_q;

endmodule

// File: rtl/encoder_decoder.sv
// Two-stage pipeline: one-hot -> binary code (sub-module), then binary -> one-hot decode (inline).
// Multi-hot handling follows ENCDEC_PRIORITY_EN inside onehot_enc_stage; the port list is the same either way.
module encoder_decoder
  import encdec_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] i,
  output logic [W-1:0] y,
  output logic         y_valid,
  output logic [N-1:0] a,
  output logic         a_valid,
  output logic         err
);

  localparam logic [N-1:0] OneN = N'(1);

  logic [N-1:0] a_q, a_d;
  logic         a_valid_q, a_valid_d;

  onehot_enc_stage #(.N(N)) u_enc (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .i        (i),
    .y        (y),
    .y_valid  (y_valid),
    .err      (err)
  );

  // Decode only qualified codes so a stale y never leaks into a.
  always_comb begin
    a_d       = '0;
    a_valid_d = y_valid;
    if (y_valid) begin
      a_d = OneN << y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      a_valid_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
    end
  end

  assign a       = a_q;
  assign a_valid = a_valid_q;

endmodule

// File: tb/tb_encoder_decoder.sv
// Self-checking bench for encoder_decoder: directed vector table plus a randomized stream
// compared against an arithmetic reference model and a two-cycle round-trip history.
module tb_encoder_decoder;
  import encdec_pkg::*;

  localparam int N = DEFAULT_N;
  localparam int W = clog2(N);

`ifdef ENCDEC_PRIORITY_EN
  localparam bit Prio = 1'b1;
`else
  localparam bit Prio = 1'b0;
`endif

  // Expected multi-hot (0110) outcome depends on the build.
  localparam logic [W-1:0] MhY     = Prio ? W'(2) : W'(3);
  localparam logic         MhYV    = Prio;
  localparam logic         MhErr   = !Prio;
  localparam logic [N-1:0] MhA     = Prio ? N'(4) : N'(0);
  localparam logic         MhAV    = Prio;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] i;
  logic [W-1:0] y;
  logic         y_valid;
  logic [N-1:0] a;
  logic         a_valid;
  logic         err;

  always #5 clk = ~clk;

  encoder_decoder #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .i        (i),
    .y        (y),
    .y_valid  (y_valid),
    .a        (a),
    .a_valid  (a_valid),
    .err      (err)
  );

  typedef struct {
    string        name;
    logic         rst;
    logic         inValid;
    logic [N-1:0] stim;
    logic [W-1:0] expY;
    logic         expYValid;
    logic         expErr;
    logic [N-1:0] expA;
    logic         expAValid;
  } vector_t;

  localparam int NumVec = 17;
  vector_t vecTable[NumVec];

  int nVectors     = 0;
  int nMiscompares = 0;

  // Reference model state: what each output should hold after the latest edge.
  logic [W-1:0] mY;
  logic         mYValid, mErr, mAValid;
  logic [N-1:0] mA;

  // Round-trip history: accepted legal one-hot inputs one and two edges back.
  logic         h1Valid, h2Valid;
  logic [N-1:0] h1Val, h2Val;

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [N-1:0] x);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    i        = x;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] eY, input logic eYV,
                             input logic eErr, input logic [N-1:0] eA, input logic eAV);
    nVectors++;
    if ({y, y_valid, err, a, a_valid} !== {eY, eYV, eErr, eA, eAV}) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got y=%b y_valid=%b err=%b a=%b a_valid=%b, expected y=%b y_valid=%b err=%b a=%b a_valid=%b",
               name, y, y_valid, err, a, a_valid, eY, eYV, eErr, eA, eAV);
    end
  endtask

  task automatic checkRoundTrip();
    if (h2Valid) begin
      nVectors++;
      if (!(a_valid === 1'b1 && a === h2Val)) begin
        nMiscompares++;
        $display("[TB] FAIL roundtrip: got a=%b a_valid=%b, expected a=%b a_valid=1", a, a_valid, h2Val);
      end
    end
  endtask

  // Behavioural model: the code is log2 of the input (highest bit for multi-hot), decode is 1<<code.
  task automatic modelStep(input logic r, input logic v, input logic [N-1:0] x);
    if (r) begin
      mY = '0; mYValid = 1'b0; mErr = 1'b0; mA = '0; mAValid = 1'b0;
    end else begin
      mA      = mYValid ? (N'(1) << mY) : '0;
      mAValid = mYValid;
      if (v && x != '0 && (Prio || $countones(x) == 1)) begin
        mY      = W'($clog2(int'(x) + 1) - 1);
        mYValid = 1'b1;
        mErr    = 1'b0;
      end else begin
        mYValid = 1'b0;
        mErr    = v;
      end
    end
  endtask

  task automatic historyStep(input logic r, input logic v, input logic [N-1:0] x);
    if (r) begin
      h1Valid = 1'b0; h2Valid = 1'b0; h1Val = '0; h2Val = '0;
    end else begin
      h2Valid = h1Valid;
      h2Val   = h1Val;
      h1Valid = v && ($countones(x) == 1);
      h1Val   = x;
    end
  endtask

  initial begin
    logic         r, v;
    logic [N-1:0] x;
    int           sel;

    rst      = 1'b1;
    in_valid = 1'b0;
    i        = '0;

    //                name          rst   iv    i        y      yv    err   a        av
    vecTable[0]  = '{"rst_discard", 1'b1, 1'b1, 4'b0100, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecTable[1]  = '{"rst_hold",    1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecTable[2]  = '{"rst_release", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecTable[3]  = '{"legal_0010",  1'b0, 1'b1, 4'b0010, 2'b01, 1'b1, 1'b0, 4'b0000, 1'b0};
    vecTable[4]  = '{"legal_0100",  1'b0, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b0, 4'b0010, 1'b1};
    vecTable[5]  = '{"legal_0001",  1'b0, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b0, 4'b0100, 1'b1};
    vecTable[6]  = '{"legal_1000",  1'b0, 1'b1, 4'b1000, 2'b11, 1'b1, 1'b0, 4'b0001, 1'b1};
    vecTable[7]  = '{"idle_drain",  1'b0, 1'b0, 4'b0000, 2'b11, 1'b0, 1'b0, 4'b1000, 1'b1};
    vecTable[8]  = '{"zero_input",  1'b0, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b1, 4'b0000, 1'b0};
    vecTable[9]  = '{"zero_decode", 1'b0, 1'b0, 4'b0000, 2'b11, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecTable[10] = '{"multi_0110",  1'b0, 1'b1, 4'b0110, MhY,   MhYV, MhErr, 4'b0000, 1'b0};
    vecTable[11] = '{"multi_dec",   1'b0, 1'b0, 4'b0000, MhY,   1'b0, 1'b0, MhA,     MhAV};
    vecTable[12] = '{"multi_drain", 1'b0, 1'b0, 4'b0000, MhY,   1'b0, 1'b0, 4'b0000, 1'b0};
    vecTable[13] = '{"mid_1000",    1'b0, 1'b1, 4'b1000, 2'b11, 1'b1, 1'b0, 4'b0000, 1'b0};
    vecTable[14] = '{"mid_rst",     1'b1, 1'b1, 4'b0010, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecTable[15] = '{"post_rst_1",  1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecTable[16] = '{"post_rst_2",  1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0};

    for (int k = 0; k < NumVec; k++) begin
      applyStimulus(vecTable[k].rst, vecTable[k].inValid, vecTable[k].stim);
      checkOutput(vecTable[k].name, vecTable[k].expY, vecTable[k].expYValid,
                  vecTable[k].expErr, vecTable[k].expA, vecTable[k].expAValid);
    end

    // The table ends with the pipeline flushed and y at zero.
    mY = '0; mYValid = 1'b0; mErr = 1'b0; mA = '0; mAValid = 1'b0;
    h1Valid = 1'b0; h2Valid = 1'b0; h1Val = '0; h2Val = '0;

    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 39) == 0);
      v   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0)      x = '0;
      else if (sel == 1) x = N'($urandom);
      else               x = N'(1) << $urandom_range(0, N - 1);
      applyStimulus(r, v, x);
      modelStep(r, v, x);
      historyStep(r, v, x);
      checkOutput("random", mY, mYValid, mErr, mA, mAValid);
      checkRoundTrip();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
